// File: rtl/demon_game_ctrl.sv
// Demon runner game sequencer: IDLE/RUN/PAUSE/OVER FSM, scroll-enable timer, difficulty ramp and score.
// Optional DEMON_HISCORE_EN adds a high-score register that keeps the best finished run until clr.
module demon_game_ctrl #(
  parameter int DIFF_INIT  = 60,
  parameter int DIFF_MIN   = 20,
  parameter int DIFF_STEP  = 4,
  parameter int RAMP_TICKS = 50,
  parameter int SCORE_W    = 14
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick_01ms,
  input  logic               tick_100ms,
  input  logic               start,
  input  logic               shut,
  input  logic               collision,
  output logic [1:0]         state,
  output logic               scroll_en,
  output logic               restart,
  output logic               frozen,
  output logic [6:0]         diff,
  output logic [SCORE_W-1:0] score
`ifdef DEMON_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [6:0]        L_DIFF_INIT  = 7'(DIFF_INIT);
  localparam logic [6:0]        L_DIFF_MIN   = 7'(DIFF_MIN);
  localparam logic [6:0]        L_DIFF_STEP  = 7'(DIFF_STEP);
  localparam logic [6:0]        L_STEP_GATE  = 7'(DIFF_MIN + DIFF_STEP);
  localparam logic [RAMP_W-1:0] L_RAMP_LAST  = RAMP_W'(RAMP_TICKS - 1);

  logic [1:0]         r_state;
  logic               r_start_d;
  logic               r_scroll_en;
  logic               r_restart;
  logic               r_frozen;
  logic [6:0]         r_diff;
  logic [6:0]         r_period_cnt;
  logic [RAMP_W-1:0]  r_ramp_cnt;
  logic [SCORE_W-1:0] r_score;

  logic [1:0] w_state_next;
  logic       w_start_edge;
  logic       w_run_stay;
  logic       w_enter_run;
  logic       w_scroll_hit;
  logic       w_ramp_hit;
  logic [6:0] w_diff_stepped;

  assign w_start_edge = start & ~r_start_d;

  always_comb begin
    w_state_next = r_state;
    w_run_stay   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_next = S_RUN;
      S_RUN: begin
        if (collision)  w_state_next = S_OVER;
        else if (shut)  w_state_next = S_PAUSE;
        else            w_run_stay   = 1'b1;
      end
      S_PAUSE: if (!shut) w_state_next = S_RUN;
      S_OVER:  if (w_start_edge) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_enter_run = (r_state == S_IDLE) && w_start_edge;

  // >= rather than == so a period shortened by the ramp fires on the next tick
  assign w_scroll_hit = w_run_stay && tick_01ms &&
                        (({1'b0, r_period_cnt} + 8'd1) >= {1'b0, r_diff});
  assign w_ramp_hit   = w_run_stay && tick_100ms && (r_ramp_cnt == L_RAMP_LAST);
  assign w_diff_stepped = (r_diff >= L_STEP_GATE) ? (r_diff - L_DIFF_STEP) : L_DIFF_MIN;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_start_d    <= 1'b0;
      r_scroll_en  <= 1'b0;
      r_restart    <= 1'b0;
      r_frozen     <= 1'b1;
      r_diff       <= L_DIFF_INIT;
      r_period_cnt <= '0;
      r_ramp_cnt   <= '0;
      r_score      <= '0;
    end else begin
      r_start_d   <= start;
      r_state     <= w_state_next;
      r_frozen    <= (w_state_next != S_RUN);
      r_restart   <= w_enter_run;
      r_scroll_en <= w_scroll_hit;
      if (w_enter_run) begin
        r_diff       <= L_DIFF_INIT;
        r_period_cnt <= '0;
        r_ramp_cnt   <= '0;
        r_score      <= '0;
      end else if (w_run_stay) begin
        // score moves on the same edge that raises scroll_en, so both are seen together
        if (tick_01ms)
          r_period_cnt <= w_scroll_hit ? 7'd0 : (r_period_cnt + 7'd1);
        if (w_scroll_hit && (r_score != {SCORE_W{1'b1}}))
          r_score <= r_score + 1'b1;
        if (tick_100ms) begin
          r_ramp_cnt <= w_ramp_hit ? '0 : (r_ramp_cnt + 1'b1);
          if (w_ramp_hit)
            r_diff <= w_diff_stepped;
        end
      end
    end
  end

`ifdef DEMON_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;

  always_ff @(posedge clk) begin
    if (clr)
      r_hiscore <= '0;
    else if ((r_state == S_RUN) && (w_state_next == S_OVER) && (r_score > r_hiscore))
      r_hiscore <= r_score;
  end

  assign hiscore = r_hiscore;
`endif

  assign state     = r_state;
  assign scroll_en = r_scroll_en;
  assign restart   = r_restart;
  assign frozen    = r_frozen;
  assign diff      = r_diff;
  assign score     = r_score;

endmodule
